alu_seq: RTL

Parametrised, registered ALU with a valid/ready handshake on both input and output. It keeps the existing 3-bit opcode map: hold, add, sub, mul, div, and, or, xor.
- Single-cycle ops complete in one cycle.
- mul/div run as iterative multi-cycle engines (shift-add and restoring divide).
- Adds status flags, the full-width product high half, and the division remainder.
- Sits between the register file / accumulator and the bus, replacing the combinational ALU in the next-generation datapath.

---
 rtl/alu_seq_pkg.sv | 16 +
 rtl/alu_seq_iter.sv | 50 +++++
 rtl/alu_seq.sv | 127 ++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, FSM state encoding and flag bit indices shared by the alu_seq block.
package alu_seq_pkg;
    localparam logic [2:0] OP_HOLD = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_SUB  = 3'd2;
    localparam logic [2:0] OP_MUL  = 3'd3;
    localparam logic [2:0] OP_DIV  = 3'd4;
    localparam logic [2:0] OP_AND  = 3'd5;
    localparam logic [2:0] OP_OR   = 3'd6;
    localparam logic [2:0] OP_XOR  = 3'd7;
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
    localparam int FLAG_Z  = 0;
    localparam int FLAG_C  = 1;
    localparam int FLAG_V  = 2;
    localparam int FLAG_DZ = 3;
endpackage

// File: rtl/alu_seq_iter.sv
// alu_seq_iter: shared iterative engine, shift-add multiply (i_mode=0) or restoring divide (i_mode=1).
// o_lo/o_hi carry the value after the current step so the caller can capture the final step directly.
module alu_seq_iter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_step,
    input  logic             i_mode,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_last,
    output logic [WIDTH-1:0] o_lo,
    output logic [WIDTH-1:0] o_hi
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_hi, r_lo, r_m;
    logic             r_mode;
    logic [WIDTH:0]   w_sum, w_shl, w_dif;
    assign w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);
    assign w_shl  = {r_hi, r_lo[WIDTH-1]};
    assign w_dif  = w_shl - {1'b0, r_m};
    assign o_last = (r_cnt == CNT_W'(1));
    // mul: {hi,lo} shifts right with the partial sum; div: remainder in hi, quotient shifts into lo
    always_comb begin
        o_hi = r_mode ? (w_dif[WIDTH] ? w_shl[WIDTH-1:0] : w_dif[WIDTH-1:0]) : w_sum[WIDTH:1];
        o_lo = r_mode ? {r_lo[WIDTH-2:0], ~w_dif[WIDTH]} : {w_sum[0], r_lo[WIDTH-1:1]};
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_m    <= '0;
            r_mode <= 1'b0;
        end else if (i_start) begin
            r_cnt  <= CNT_W'(WIDTH);
            r_hi   <= '0;
            r_lo   <= i_mode ? i_a : i_b;
            r_m    <= i_mode ? i_b : i_a;
            r_mode <= i_mode;
        end else if (i_step) begin
            r_cnt <= r_cnt - CNT_W'(1);
            r_hi  <= o_hi;
            r_lo  <= o_lo;
        end
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshake; mul/div engines only when ALU_SEQ_MULDIV_EN is defined,
// otherwise ops 011/100 complete in one cycle flagged unsupported through flag_dz.
import alu_seq_pkg::*;
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v,
    output logic             flag_dz
);
    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_result, r_result_hi, w_res, w_hi, w_it_lo, w_it_hi;
    logic [3:0]       r_flags;
    logic [WIDTH:0]   w_sum, w_dif;
    logic             w_c, w_v, w_dz, w_upd, w_start, w_last, w_busy;
    assign w_sum  = {1'b0, a} + {1'b0, b};
    assign w_dif  = {1'b0, a} - {1'b0, b};
    assign w_busy = (r_state == S_MUL) || (r_state == S_DIV);
`ifdef ALU_SEQ_MULDIV_EN
    assign w_start = (r_state == S_IDLE) && in_valid && ((op == OP_MUL) || ((op == OP_DIV) && (b != '0)));
    alu_seq_iter #(.WIDTH(WIDTH)) u_iter (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_start),
        .i_step  (w_busy),
        .i_mode  (op == OP_DIV),
        .i_a     (a),
        .i_b     (b),
        .o_last  (w_last),
        .o_lo    (w_it_lo),
        .o_hi    (w_it_hi)
    );
`else
    assign w_start = 1'b0;
    assign w_last  = 1'b0;
    assign w_it_lo = '0;
    assign w_it_hi = '0;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:       if (in_valid) w_next = w_start ? ((op == OP_MUL) ? S_MUL : S_DIV) : S_DONE;
            S_MUL, S_DIV: if (w_last) w_next = S_DONE;
            default:      if (out_ready) w_next = S_IDLE;
        endcase
    end
    always_comb begin
        in_ready  = (r_state == S_IDLE);
        out_valid = (r_state == S_DONE);
    end
    // hold completes without touching the result registers
    always_comb begin
        w_res = '0;
        w_hi  = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        w_dz  = 1'b0;
        w_upd = ((r_state == S_IDLE) && in_valid && (op != OP_HOLD) && !w_start) || (w_busy && w_last);
        if (w_busy) begin
            w_res = w_it_lo;
            w_hi  = w_it_hi;
            w_c   = (r_state == S_MUL) && (|w_it_hi);
        end else begin
            case (op)
                OP_ADD: begin
                    w_res = w_sum[WIDTH-1:0];
                    w_c   = w_sum[WIDTH];
                    w_v   = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
                end
                OP_SUB: begin
                    w_res = w_dif[WIDTH-1:0];
                    w_c   = w_dif[WIDTH];
                    w_v   = (a[WIDTH-1] != b[WIDTH-1]) && (w_dif[WIDTH-1] != a[WIDTH-1]);
                end
                OP_AND: w_res = a & b;
                OP_OR:  w_res = a | b;
                OP_XOR: w_res = a ^ b;
`ifdef ALU_SEQ_MULDIV_EN
                OP_DIV: begin
                    w_res = '1;
                    w_hi  = a;
                    w_dz  = 1'b1;
                end
`else
                OP_MUL, OP_DIV: w_dz = 1'b1;
`endif
                default: ;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result    <= '0;
            r_result_hi <= '0;
            r_flags     <= '0;
        end else if (w_upd) begin
            r_result         <= w_res;
            r_result_hi      <= w_hi;
            r_flags[FLAG_Z]  <= (w_res == '0);
            r_flags[FLAG_C]  <= w_c;
            r_flags[FLAG_V]  <= w_v;
            r_flags[FLAG_DZ] <= w_dz;
        end
    end
    assign result    = r_result;
    assign result_hi = r_result_hi;
    assign flag_z    = r_flags[FLAG_Z];
    assign flag_c    = r_flags[FLAG_C];
    assign flag_v    = r_flags[FLAG_V];
    assign flag_dz   = r_flags[FLAG_DZ];
endmodule
